// File: rtl/mul24_share_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul24_share_arbiter : round-robin sharing of one 24x24 Booth/Wallace mult |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+

module mul24_booth (
   input  logic        signed_mode,
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic [47:0] product
);
   logic [47:0]       ae;
   logic [26:0]       bz;
   logic [12:0][47:0] pp;
   logic [8:0][47:0]  l1;
   logic [5:0][47:0]  l2;
   logic [3:0][47:0]  l3;
   logic [2:0][47:0]  l4;
   logic [1:0][47:0]  l5;

   function automatic logic [95:0] csa(input logic [47:0] x, input logic [47:0] y,
                                       input logic [47:0] z);
      logic [47:0] carry;
      carry = ((x & y) | (x & z) | (y & z)) << 1;
      return {carry, x ^ y ^ z};
   endfunction

   // Operands widen to 26-bit two's complement so one Booth scheme covers both modes
   assign ae = {{24{signed_mode & a[23]}}, a};
   assign bz = {{2{signed_mode & b[23]}}, b, 1'b0};

   for (genvar i = 0; i < 13; i++) begin : g_pp
      logic [2:0]  t;
      logic [47:0] m;
      logic [47:0] row;
      assign t   = bz[2*i+2 : 2*i];
      assign m   = (t == 3'b011 || t == 3'b100) ? {ae[46:0], 1'b0} : ae;
      assign row = (t == 3'b000 || t == 3'b111) ? 48'd0 :
                   (t[2] ? (~m + 48'd1) : m);
      assign pp[i] = row << (2 * i);
   end

   // Wallace reduction 13 -> 9 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add
   for (genvar j = 0; j < 4; j++) begin : g_l1
      assign {l1[2*j+1], l1[2*j]} = csa(pp[3*j], pp[3*j+1], pp[3*j+2]);
   end
   assign l1[8] = pp[12];

   for (genvar j = 0; j < 3; j++) begin : g_l2
      assign {l2[2*j+1], l2[2*j]} = csa(l1[3*j], l1[3*j+1], l1[3*j+2]);
   end

   for (genvar j = 0; j < 2; j++) begin : g_l3
      assign {l3[2*j+1], l3[2*j]} = csa(l2[3*j], l2[3*j+1], l2[3*j+2]);
   end

   assign {l4[1], l4[0]} = csa(l3[0], l3[1], l3[2]);
   assign l4[2]          = l3[3];
   assign {l5[1], l5[0]} = csa(l4[0], l4[1], l4[2]);
   assign product        = l5[0] + l5[1];
endmodule

module mul24_share_arbiter #(
   parameter int N_REQ      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int IDW        = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ-1:0]    req_signed,
   input  logic [N_REQ*24-1:0] req_a,
   input  logic [N_REQ*24-1:0] req_b,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [IDW-1:0]      resp_id,
   output logic [47:0]         resp_product,
   output logic                busy
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [23:0]    a_arr [N_REQ];
   logic [23:0]    b_arr [N_REQ];

   logic [IDW-1:0] ptr;
   logic [CW-1:0]  credits;
   logic           any_valid;
   logic [IDW-1:0] win;
   logic           issue;
   logic           pop;

   logic           s1_valid;
   logic [23:0]    s1_a;
   logic [23:0]    s1_b;
   logic           s1_signed;
   logic [IDW-1:0] s1_id;
   logic [47:0]    mul_product;

   logic           s2_valid;
   logic [IDW-1:0] s2_id;
   logic [47:0]    s2_product;

   logic [IDW-1:0] mem_id      [FIFO_DEPTH];
   logic [47:0]    mem_product [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[24*g +: 24];
      assign b_arr[g] = req_b[24*g +: 24];
   end

   // Round-robin search starting one past the last winner
   always_comb begin : arb_search
      logic [IDW-1:0] cand;
      any_valid = 1'b0;
      win       = '0;
      cand      = ptr;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (cand == IDW'(N_REQ - 1)) ? '0 : cand + IDW'(1);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            win       = cand;
         end
      end
   end

   // Only the registered credit count gates issue, keeping resp_ready off this path
   assign req_ready = (rst_n && any_valid && credits != '0) ? (N_REQ'(1) << win) : '0;
   assign issue     = |(req_valid & req_ready);
   assign pop       = resp_valid & resp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= IDW'(N_REQ - 1);
         credits <= CW'(FIFO_DEPTH);
      end else begin
         if (issue) begin
            ptr <= win;
         end
         case ({issue, pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_signed  <= 1'b0;
         s1_id      <= '0;
         s2_valid   <= 1'b0;
         s2_id      <= '0;
         s2_product <= '0;
      end else begin
         s1_valid <= issue;
         if (issue) begin
            s1_a      <= a_arr[win];
            s1_b      <= b_arr[win];
            s1_signed <= req_signed[win];
            s1_id     <= win;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_id      <= s1_id;
            s2_product <= mul_product;
         end
      end
   end

   mul24_booth u_mul (
      .signed_mode (s1_signed),
      .a           (s1_a),
      .b           (s1_b),
      .product     (mul_product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (s2_valid) begin
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({s2_valid, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty
   always_ff @(posedge clk) begin
      if (s2_valid) begin
         mem_id[wr_ptr]      <= s2_id;
         mem_product[wr_ptr] <= s2_product;
      end
   end

   assign resp_valid   = (count != '0);
   assign resp_id      = resp_valid ? mem_id[rd_ptr] : '0;
   assign resp_product = resp_valid ? mem_product[rd_ptr] : '0;
   assign busy         = s1_valid | s2_valid | resp_valid;
endmodule

`default_nettype wire

// File: tb/tb_mul24_share_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mul24_share_arbiter : self-checking bench for mul24_share_arbiter      |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+

module tb_mul24_share_arbiter;
   localparam int N   = 4;
   localparam int D   = 4;
   localparam int IDW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_signed;
   logic [N*24-1:0] req_a;
   logic [N*24-1:0] req_b;
   logic            resp_valid;
   logic            resp_ready;
   logic [IDW-1:0]  resp_id;
   logic [47:0]     resp_product;
   logic            busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          id;
      logic [47:0] prod;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   mptr;
   int   cyc;

   mul24_share_arbiter #(.N_REQ(N), .FIFO_DEPTH(D), .IDW(IDW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_signed   (req_signed),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_id      (resp_id),
      .resp_product (resp_product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b,
                                           input logic s);
      longint x;
      longint y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return 48'(x * y);
   endfunction

   function automatic logic [23:0] rand24();
      case ($urandom_range(0, 5))
         0:       return 24'h000000;
         1:       return 24'h800000;
         2:       return 24'hFFFFFF;
         3:       return 24'h7FFFFF;
         default: return 24'($urandom);
      endcase
   endfunction

   function automatic logic [47:0] req_prod(input int i);
      return ref_mul(req_a[24*i +: 24], req_b[24*i +: 24], req_signed[i]);
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Round-robin rule applied to the model's own pointer and outstanding-item count
   function automatic logic [N-1:0] exp_grant();
      int idx;
      if (q.size() >= D) return '0;
      for (int k = 1; k <= N; k++) begin
         idx = (mptr + k) % N;
         if (req_valid[idx]) return N'(1) << idx;
      end
      return '0;
   endfunction

   function automatic logic exp_rvalid();
      return (q.size() > 0) && (cyc >= q[0].cyc + 3);
   endfunction

   task automatic set_req(input int i, input logic v, input logic [23:0] a,
                          input logic [23:0] b, input logic s);
      req_valid[i]       = v;
      req_a[24*i +: 24]  = a;
      req_b[24*i +: 24]  = b;
      req_signed[i]      = s;
   endtask

   task automatic rand_req(input int i);
      set_req(i, 1'b1, rand24(), rand24(), 1'($urandom));
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      req_signed = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      mptr = N - 1;
      cyc  = 0;
   endtask

   // Drives one request, returns the cycle distance from handshake to resp_valid
   task automatic issue_one(input int id, input logic [23:0] a, input logic [23:0] b,
                            input logic s, output int lat, output logic [IDW-1:0] rid,
                            output logic [47:0] rprod);
      int t;
      t = 0;
      set_req(id, 1'b1, a, b, s);
      resp_ready = 1'b1;
      @(negedge clk);
      while (!req_ready[id] && t < 20) begin
         @(posedge clk); #1; @(negedge clk); t++;
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1; @(negedge clk); lat++;
      end
      rid   = resp_id;
      rprod = resp_product;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = '1;
      for (int i = 0; i < N; i++) rand_req(i);
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      total++; if (resp_id !== '0) begin bad++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
      total++; if (resp_product !== '0) begin bad++; $display("FAIL rst_resp_product: got %h want 0", resp_product); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      req_valid = 4'b0100;
      @(negedge clk);
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rst_first_grant: got %b want 0100", req_ready); end
      do_reset();
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 24'd3, 24'd5, 1'b0);
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_c0: got %b want 0", busy); end
      @(posedge clk); #1;
      req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_c%0d: got %b want 1", c, busy); end
         total++; if (resp_valid !== (c == 3)) begin bad++; $display("FAIL single_rvalid_c%0d: got %b want %b", c, resp_valid, c == 3); end
         if (c == 3) begin
            total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", resp_id); end
            total++; if (resp_product !== 48'h00000000000F) begin bad++; $display("FAIL single_product: got %h want 00000000000f", resp_product); end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b rvalid=%b want 0 0", busy, resp_valid); end
      do_reset();
   endtask

   task automatic test_signed_corners();
      int          ids [4]  = '{1, 2, 3, 0};
      logic [23:0] av  [4]  = '{24'h800000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      logic [23:0] bv  [4]  = '{24'h800000, 24'h000002, 24'h000002, 24'hFFFFFF};
      logic        sv  [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [47:0] ev  [4]  = '{48'h400000000000, 48'hFFFFFFFFFFFE, 48'h000001FFFFFE, 48'hFFFFFE000001};
      int          lat;
      logic [IDW-1:0] rid;
      logic [47:0]    rp;
      for (int k = 0; k < 4; k++) begin
         issue_one(ids[k], av[k], bv[k], sv[k], lat, rid, rp);
         total++; if (lat !== 3) begin bad++; $display("FAIL corner%0d_latency: got %0d want 3", k, lat); end
         total++; if (rid !== IDW'(ids[k])) begin bad++; $display("FAIL corner%0d_id: got %0d want %0d", k, rid, ids[k]); end
         total++; if (rp !== ev[k]) begin bad++; $display("FAIL corner%0d_product: got %h want %h", k, rp, ev[k]); end
      end
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [47:0] pq[$];
      for (int i = 0; i < N; i++) rand_req(i);
      resp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         total++; if (req_ready !== (N'(1) << (c % N))) begin bad++; $display("FAIL rr_grant_c%0d: got %b want %b", c, req_ready, N'(1) << (c % N)); end
         pq.push_back(req_prod(c % N));
         total++; if (resp_valid !== (c >= 3)) begin bad++; $display("FAIL rr_rvalid_c%0d: got %b want %b", c, resp_valid, c >= 3); end
         if (c >= 3) begin
            total++; if (resp_id !== IDW'((c - 3) % N)) begin bad++; $display("FAIL rr_id_c%0d: got %0d want %0d", c, resp_id, (c - 3) % N); end
            total++; if (resp_product !== pq[0]) begin bad++; $display("FAIL rr_product_c%0d: got %h want %h", c, resp_product, pq[0]); end
            void'(pq.pop_front());
         end
         @(posedge clk); #1;
         rand_req(c % N);
      end
      do_reset();
   endtask

   task automatic test_backpressure();
      int          iq[$];
      logic [47:0] pq[$];
      int          hs;
      int          g;
      hs = 0;
      for (int i = 0; i < N; i++) rand_req(i);
      resp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         g = onehot_idx(req_ready);
         if (g >= 0) begin hs++; iq.push_back(g); pq.push_back(req_prod(g)); end
         @(posedge clk); #1;
         if (g >= 0) rand_req(g);
      end
      total++; if (hs !== D) begin bad++; $display("FAIL bp_handshakes: got %0d want %0d", hs, D); end
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_no_issue_on_pop: got %b want 0", req_ready); end
      total++; if (resp_valid !== 1'b1 || resp_id !== IDW'(iq[0]) || resp_product !== pq[0]) begin
         bad++; $display("FAIL bp_head: got v=%b id=%0d p=%h want 1 %0d %h", resp_valid, resp_id, resp_product, iq[0], pq[0]);
      end
      void'(iq.pop_front()); void'(pq.pop_front());
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_refill_grant: got %b want 0001", req_ready); end
      iq.push_back(0); pq.push_back(req_prod(0));
      @(posedge clk); #1;
      rand_req(0);
      @(negedge clk);
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_full_again: got %b want 0", req_ready); end
      @(posedge clk); #1;
      req_valid  = '0;
      resp_ready = 1'b1;
      for (int t = 0; t < 30 && iq.size() > 0; t++) begin
         @(negedge clk);
         if (resp_valid) begin
            total++; if (resp_id !== IDW'(iq[0]) || resp_product !== pq[0]) begin
               bad++; $display("FAIL bp_drain_order: got id=%0d p=%h want %0d %h", resp_id, resp_product, iq[0], pq[0]);
            end
            void'(iq.pop_front()); void'(pq.pop_front());
         end
         @(posedge clk); #1;
      end
      total++; if (iq.size() !== 0) begin bad++; $display("FAIL bp_drain_count: got %0d left want 0", iq.size()); end
      do_reset();
   endtask

   task automatic test_back_to_back();
      int hs;
      int pops;
      hs   = 0;
      pops = 0;
      for (int i = 0; i < N; i++) rand_req(i);
      resp_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (|req_ready) hs++;
         if (resp_valid) pops++;
         @(posedge clk); #1;
      end
      total++; if (hs !== 24) begin bad++; $display("FAIL b2b_issue_rate: got %0d want 24", hs); end
      total++; if (pops !== 21) begin bad++; $display("FAIL b2b_pop_rate: got %0d want 21", pops); end
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [47:0] ep;
      for (int i = 0; i < N; i++) rand_req(i);
      resp_ready = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      total++; if (busy !== 1'b1 || resp_valid !== 1'b1) begin bad++; $display("FAIL mid_preload: got busy=%b rvalid=%b want 1 1", busy, resp_valid); end
      rst_n = 1'b0;
      #1;
      total++; if (req_ready !== '0 || resp_valid !== 1'b0 || resp_id !== '0 || resp_product !== '0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset_outputs: got rdy=%b v=%b id=%0d p=%h busy=%b want all 0", req_ready, resp_valid, resp_id, resp_product, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) rand_req(i);
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
      ep = req_prod(0);
      @(posedge clk); #1;
      req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         total++; if (resp_valid !== (c == 3)) begin bad++; $display("FAIL mid_rvalid_c%0d: got %b want %b", c, resp_valid, c == 3); end
         if (c == 3) begin
            total++; if (resp_id !== 2'd0 || resp_product !== ep) begin bad++; $display("FAIL mid_result: got id=%0d p=%h want 0 %h", resp_id, resp_product, ep); end
         end
         @(posedge clk); #1;
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      logic         erv;
      int           gi;
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(0, 2) != 0) rand_req(i);
         resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         g   = exp_grant();
         erv = exp_rvalid();
         total++; if (req_ready !== g) begin bad++; $display("FAIL rnd_grant_c%0d: got %b want %b", cyc, req_ready, g); end
         total++; if (resp_valid !== erv) begin bad++; $display("FAIL rnd_rvalid_c%0d: got %b want %b", cyc, resp_valid, erv); end
         total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL rnd_busy_c%0d: got %b want %b", cyc, busy, q.size() != 0); end
         if (erv) begin
            total++; if (resp_id !== IDW'(q[0].id) || resp_product !== q[0].prod) begin
               bad++; $display("FAIL rnd_result_c%0d: got id=%0d p=%h want %0d %h", cyc, resp_id, resp_product, q[0].id, q[0].prod);
            end
         end
         if (resp_ready && erv) void'(q.pop_front());
         gi = onehot_idx(g);
         if (gi >= 0) begin
            q.push_back('{id: gi, prod: req_prod(gi), cyc: cyc});
            mptr = gi;
         end
         @(posedge clk); #1;
         cyc++;
         if (gi >= 0) begin
            if ($urandom_range(0, 1) != 0) rand_req(gi);
            else req_valid[gi] = 1'b0;
         end
      end
      do_reset();
   endtask

   initial begin
      do_reset();
      test_reset();
      test_single();
      test_signed_corners();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/mul24_share_arbiter.md
Name: mul24_share_arbiter

Overview:
- Shares one 24x24 radix-4 Booth/Wallace multiplier between N_REQ independent requesters.
- Round-robin arbitration, a two-register pipeline around the combinational multiplier, and an in-order result FIFO with credit-based backpressure.
- Sits between the integer/FPU mantissa issue logic and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FIFO_DEPTH, 4, result FIFO entries; also the total credit count (>=3).
- IDW, $clog2(N_REQ), width of the requester-ID tag.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_signed  input  N_REQ  per-requester signedFlag (1 = signed, 0 = unsigned).
- req_a  input  N_REQ*24  packed multiplicands; requester i occupies [24i+23:24i].
- req_b  input  N_REQ*24  packed multipliers, same packing as req_a.
- resp_valid  output  1  FIFO head valid.
- resp_ready  input  1  consumer accepts the head.
- resp_id  output  IDW  requester index of the head result.
- resp_product  output  48  product at the head.
- busy  output  1  high while any pipeline stage or FIFO entry is occupied.

Behaviour:
- Reset (async, rst_n=0): req_ready=0, resp_valid=0, resp_id=0, resp_product=0, busy=0, all stage valids=0, FIFO empty, credits=FIFO_DEPTH, RR pointer=N_REQ-1, so requester 0 has first priority.
- Credits:
  - credits = FIFO_DEPTH - (s1_valid + s2_valid + fifo_count), held as a registered counter.
  - An issue decrements the counter; a pop (resp_valid & resp_ready) increments it; both in the same cycle leave it unchanged.
  - Issue is allowed only when the registered credit count is >0. A pop in the same cycle does not enable an issue that cycle, so there is no combinational path from resp_ready to req_ready.
- Arbitration:
  - Candidates are req_valid bits. Search starts at ptr+1 and wraps modulo N_REQ.
  - Winner g gets req_ready[g]=1 only if credits>0; otherwise all req_ready=0.
  - req_ready depends combinationally on req_valid and registered state only.
  - On handshake (req_valid[g]&req_ready[g]), ptr<=g. With no handshake, ptr holds.
  - A requester must hold its valid and operands stable until accepted.
- Pipeline:
  - Handshake in cycle k: {a,b,signed,id} are captured into S1 at the end of cycle k.
  - Cycle k+1: the multiplier computes combinationally from S1; the result is captured into S2 at the end of cycle k+1.
  - Cycle k+2: S2 is written into the FIFO.
  - Earliest resp_valid is cycle k+3 (latency 3 when the FIFO is empty).
  - Stages never stall: credits guarantee FIFO space for everything in flight.
- Arithmetic:
  - Unsigned: product = a*b, 48 bits.
  - Signed: two's-complement a*b, 48 bits.
  - The signedFlag travels with its operands.
- FIFO:
  - Circular buffer, FIFO_DEPTH entries of {id, product}, with read/write pointers that wrap at FIFO_DEPTH.
  - Write and read in the same cycle are both performed, including when the FIFO is full with a pop, and when it is empty, where the write lands and resp_valid rises the following cycle. There is no fall-through.
  - resp_id and resp_product are driven from the head entry. They are 0 when the FIFO is empty and hold stable while resp_valid & !resp_ready.
- Ordering: results leave in issue order, regardless of requester.
- busy = s1_valid | s2_valid | (fifo_count != 0).
- Reset mid-operation: in-flight and buffered results are discarded; behaviour is as for reset.

Test Plan:
- Single unsigned request: req0 a=3, b=5, handshake at cycle 0 -> resp_valid at cycle 3 with id=0, product=0x00000000000F; busy high cycles 1-3.
- Signed corners:
  - req1 a=0x800000, b=0x800000, signed -> 0x400000000000.
  - req2 a=0xFFFFFF, b=0x000002, signed -> 0xFFFFFFFFFFFE.
  - Same 0xFFFFFF x 0x000002 operands, unsigned -> 0x000001FFFFFE.
  - 0xFFFFFF x 0xFFFFFF, unsigned -> 0xFFFFFE000001.
- Round-robin fairness: all four req_valid held high, resp_ready=1 -> grants 0,1,2,3,0,1... one per cycle, and resp_id follows the same sequence 3 cycles later.
- Backpressure: resp_ready=0 with continuous requests -> exactly 4 handshakes, then req_ready=0. Pulse resp_ready for 1 cycle -> one pop, then one new handshake on the next cycle. Results remain in order.
- Simultaneous pop and issue at credits=1 -> counter stays at 1; sustained throughput is 1 result per cycle with resp_ready=1.
- Reset mid-operation: assert rst_n=0 with 2 in flight and 2 buffered -> all outputs 0 immediately. After release, a request from requester 0 (alongside others) is granted first and its result returns with latency 3.
